// File: rtl/jk_ff_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jk_ff_checker                                                |
// | Description : Self-test sequencer for an external JK flip-flop. It resets   |
// |               the flip-flop, checks the reset value, then applies an       |
// |               8-step (j,k) vector table PASSES times. After every step it  |
// |               compares q/q_bar against an internal expected model and       |
// |               keeps a saturating mismatch count.                            |
// | Ports       : clk      - rising-edge clock                                  |
// |               rst      - synchronous active-low reset                       |
// |               start    - begin a run (honoured only in IDLE or DONE)        |
// |               q, q_bar - flip-flop outputs under test                       |
// |               j, k     - registered drives to the flip-flop                 |
// |               dut_rst  - registered active-high reset to the flip-flop      |
// |               busy     - run in progress                                    |
// |               done     - run finished, held until the next start            |
// |               pass     - done with zero mismatches                          |
// |               err_cnt  - saturating mismatch count                          |
// |               step     - index of the current vector (0..7)                 |
// | Revision    : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module jk_ff_checker #(
  parameter int PASSES = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q,
  input  logic             q_bar,
  output logic             j,
  output logic             k,
  output logic             dut_rst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       step
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RSTD  = 3'd1,
    S_RCHK  = 3'd2,
    S_APPLY = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Vector table, bit i holds the value for step i.
  // Steps 0..7 (j,k): 01 00 10 00 11 11 01 11
  localparam logic [7:0]       c_vec_j     = 8'b1011_0100;
  localparam logic [7:0]       c_vec_k     = 8'b1111_0001;
  localparam logic [3:0]       c_last_pass = 4'(PASSES - 1);
  localparam logic [ERR_W-1:0] c_err_max   = '1;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_rstd_cnt;
  logic             w_rstd_cnt_nx;
  logic [3:0]       r_pass_cnt;
  logic [3:0]       w_pass_cnt_nx;
  logic             r_exp_q;
  logic             w_exp_q_nx;
  logic [2:0]       w_step_nx;
  logic [ERR_W-1:0] w_err_nx;
  logic             w_cmp;
  logic             w_match;
  logic             w_miss;
  logic             w_j_nx;
  logic             w_k_nx;
  logic             w_dut_rst_nx;
  logic             w_busy_nx;
  logic             w_done_nx;
  logic             w_pass_nx;

  always_comb begin
    w_state_nx    = r_state;
    w_rstd_cnt_nx = r_rstd_cnt;
    w_pass_cnt_nx = r_pass_cnt;
    w_exp_q_nx    = r_exp_q;
    w_step_nx     = step;
    w_err_nx      = err_cnt;
    w_cmp         = 1'b0;
    w_match       = 1'b1;
    w_miss        = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nx    = S_RSTD;
          w_rstd_cnt_nx = 1'b0;
          w_pass_cnt_nx = 4'd0;
          w_step_nx     = 3'd0;
          w_err_nx      = '0;
        end
      end
      S_RSTD: begin
        // Two cycles of reset: the counter marks the second one.
        w_rstd_cnt_nx = 1'b1;
        if (r_rstd_cnt) begin
          w_state_nx = S_RCHK;
        end
      end
      S_RCHK: begin
        w_cmp      = 1'b1;
        w_match    = (q == 1'b0) && (q_bar == 1'b1);
        w_exp_q_nx = 1'b0;
        w_state_nx = S_APPLY;
      end
      S_APPLY: begin
        case ({c_vec_j[step], c_vec_k[step]})
          2'b01:   w_exp_q_nx = 1'b0;
          2'b10:   w_exp_q_nx = 1'b1;
          2'b11:   w_exp_q_nx = ~r_exp_q;
          default: w_exp_q_nx = r_exp_q;
        endcase
        w_state_nx = S_CHECK;
      end
      S_CHECK: begin
        w_cmp   = 1'b1;
        w_match = (q == r_exp_q) && (q_bar == ~q);
        if (step == 3'd7) begin
          if (r_pass_cnt != c_last_pass) begin
            w_pass_cnt_nx = r_pass_cnt + 4'd1;
            w_step_nx     = 3'd0;
            w_state_nx    = S_APPLY;
          end else begin
            w_state_nx = S_DONE;
          end
        end else begin
          w_step_nx  = step + 3'd1;
          w_state_nx = S_APPLY;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    // An unknown match result takes the else branch, so X/Z on q or q_bar
    // is counted as a mismatch.
    if (w_match) begin
      w_miss = 1'b0;
    end else begin
      w_miss = 1'b1;
    end

    if (w_cmp && w_miss && (w_err_nx != c_err_max)) begin
      w_err_nx = w_err_nx + ERR_W'(1);
    end

    // Outputs are decoded from the next state and registered below, so they
    // line up with the state they describe.
    w_busy_nx    = (w_state_nx != S_IDLE) && (w_state_nx != S_DONE);
    w_done_nx    = (w_state_nx == S_DONE);
    w_pass_nx    = (w_state_nx == S_DONE) && (w_err_nx == '0);
    w_dut_rst_nx = (w_state_nx == S_RSTD);
    w_j_nx       = (w_state_nx == S_APPLY) && c_vec_j[w_step_nx];
    w_k_nx       = (w_state_nx == S_APPLY) && c_vec_k[w_step_nx];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rstd_cnt <= 1'b0;
      r_pass_cnt <= 4'd0;
      r_exp_q    <= 1'b0;
      step       <= 3'd0;
      err_cnt    <= '0;
      j          <= 1'b0;
      k          <= 1'b0;
      dut_rst    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_rstd_cnt <= w_rstd_cnt_nx;
      r_pass_cnt <= w_pass_cnt_nx;
      r_exp_q    <= w_exp_q_nx;
      step       <= w_step_nx;
      err_cnt    <= w_err_nx;
      j          <= w_j_nx;
      k          <= w_k_nx;
      dut_rst    <= w_dut_rst_nx;
      busy       <= w_busy_nx;
      done       <= w_done_nx;
      pass       <= w_pass_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_ff_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_jk_ff_checker                                             |
// | Description : Bench for jk_ff_checker. Instance A (PASSES=1, ERR_W=8) and  |
// |               instance B (PASSES=2, ERR_W=2) each drive a behavioural JK   |
// |               flip-flop that can be faulted: 0 correct, 1 toggle acts as   |
// |               hold, 2 q_bar tied to q, 3 q stuck at 1.                     |
// | Revision    : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_jk_ff_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [1:0] mode_a, mode_b;
  logic       mq_a = 1'b0, mq_b = 1'b0;
  logic       q_a, qb_a, q_b, qb_b;
  logic       j_a, k_a, dr_a, busy_a, done_a, pass_a;
  logic       j_b, k_b, dr_b, busy_b, done_b, pass_b;
  logic [7:0] err_a;
  logic [1:0] err_b;
  logic [2:0] step_a, step_b;

  int n_checks = 0;
  int n_err    = 0;

  bit vec_j [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  bit vec_k [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  typedef struct {
    int lat;
    int err;
    bit pass;
  } exp_t;

  exp_t       sb_q  [$];
  logic [2:0] cyc_q [$];

  always #5 clk = ~clk;

  jk_ff_checker #(.PASSES(1), .ERR_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .q(q_a), .q_bar(qb_a),
    .j(j_a), .k(k_a), .dut_rst(dr_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .step(step_a)
  );

  jk_ff_checker #(.PASSES(2), .ERR_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .q(q_b), .q_bar(qb_b),
    .j(j_b), .k(k_b), .dut_rst(dr_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .step(step_b)
  );

  // Behavioural flip-flops under test
  always @(posedge clk) begin
    if (dr_a) mq_a <= 1'b0;
    else case ({j_a, k_a})
      2'b01: mq_a <= 1'b0;
      2'b10: mq_a <= 1'b1;
      2'b11: if (mode_a != 2'd1) mq_a <= ~mq_a;
      default: ;
    endcase
  end
  always @(posedge clk) begin
    if (dr_b) mq_b <= 1'b0;
    else case ({j_b, k_b})
      2'b01: mq_b <= 1'b0;
      2'b10: mq_b <= 1'b1;
      2'b11: if (mode_b != 2'd1) mq_b <= ~mq_b;
      default: ;
    endcase
  end
  assign q_a  = (mode_a == 2'd3) ? 1'b1 : mq_a;
  assign qb_a = (mode_a == 2'd2) ? q_a : ~q_a;
  assign q_b  = (mode_b == 2'd3) ? 1'b1 : mq_b;
  assign qb_b = (mode_b == 2'd2) ? q_b : ~q_b;

  // Instance select for the shared run task
  bit         sel = 1'b0;
  logic       j_s, k_s, dr_s, busy_s, done_s, pass_s;
  logic [7:0] err_s;
  logic [2:0] step_s;
  assign j_s    = sel ? j_b    : j_a;
  assign k_s    = sel ? k_b    : k_a;
  assign dr_s   = sel ? dr_b   : dr_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign pass_s = sel ? pass_b : pass_a;
  assign err_s  = sel ? {6'd0, err_b} : err_a;
  assign step_s = sel ? step_b : step_a;

  // Reference: expected mismatch count of a complete run against a faulted
  // flip-flop, derived from the vector table and the flip-flop behaviour.
  function automatic int predict_err(input logic [1:0] md, input int passes, input int errw);
    int e, emax;
    bit m, ex, oq, oqb;
    e = 0; emax = (1 << errw) - 1; m = 1'b0; ex = 1'b0;
    oq  = (md == 2'd3) ? 1'b1 : m;
    oqb = (md == 2'd2) ? oq : ~oq;
    if (oq != 1'b0 || oqb != 1'b1) e = (e < emax) ? e + 1 : e;
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s < 8; s++) begin
        case ({vec_j[s], vec_k[s]})
          2'b01: begin m = 1'b0; ex = 1'b0; end
          2'b10: begin m = 1'b1; ex = 1'b1; end
          2'b11: begin if (md != 2'd1) m = ~m; ex = ~ex; end
          default: ;
        endcase
        oq  = (md == 2'd3) ? 1'b1 : m;
        oqb = (md == 2'd2) ? oq : ~oq;
        if (oq != ex || oqb != ~oq) e = (e < emax) ? e + 1 : e;
      end
    end
    return e;
  endfunction

  // One complete run: push expectations, pulse start, compare every cycle's
  // drives and the final result against the scoreboard.
  task automatic run_scored(input bit s, input logic [1:0] md, input int passes,
                            input int errw, input bit poke, input string name);
    exp_t       e;
    int         cyc, n11;
    bit         prev11;
    logic [2:0] exp3;
    sel = s;
    if (s) mode_b = md; else mode_a = md;
    e.lat  = 3 + 16 * passes;
    e.err  = predict_err(md, passes, errw);
    e.pass = (e.err == 0);
    sb_q.push_back(e);
    for (int c = 0; c <= 2 + 16 * passes; c++) begin
      if (c < 2)                 cyc_q.push_back(3'b100);
      else if (c == 2)           cyc_q.push_back(3'b000);
      else if (((c - 3) % 2) == 0)
        cyc_q.push_back({1'b0, logic'(vec_j[((c - 3) / 2) % 8]), logic'(vec_k[((c - 3) / 2) % 8])});
      else                       cyc_q.push_back(3'b000);
    end

    @(negedge clk);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;

    n_checks++;
    if (done_s !== 1'b0 || err_s !== 8'd0 || step_s !== 3'd0 || busy_s !== 1'b1) begin
      n_err++;
      $display("FAIL %s start_clear: done=%b err=%0d step=%0d busy=%b, required 0 0 0 1",
               name, done_s, err_s, step_s, busy_s);
    end

    cyc = 0; n11 = 0; prev11 = 1'b0;
    while (done_s !== 1'b1 && cyc < 100) begin
      exp3 = (cyc_q.size() > 0) ? cyc_q.pop_front() : 3'bxxx;
      n_checks++;
      if ({dr_s, j_s, k_s} !== exp3 || busy_s !== 1'b1) begin
        n_err++;
        $display("FAIL %s drive cyc=%0d: {dut_rst,j,k}=%b busy=%b, required %b busy=1",
                 name, cyc, {dr_s, j_s, k_s}, busy_s, exp3);
      end
      if (j_s && k_s) begin
        n11++;
        n_checks++;
        if (prev11) begin
          n_err++;
          $display("FAIL %s jk11_consec cyc=%0d: j=k=1 two cycles running, required single", name, cyc);
        end
      end
      prev11 = j_s && k_s;
      if (poke) begin
        if (s) start_b = ((cyc % 5) == 2) && (cyc < 15);
        else   start_a = ((cyc % 5) == 2) && (cyc < 15);
      end
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0; start_b = 1'b0;

    e = sb_q.pop_front();
    n_checks++;
    if (cyc != e.lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, e.lat);
    end
    n_checks++;
    if (err_s !== 8'(e.err) || pass_s !== e.pass) begin
      n_err++;
      $display("FAIL %s result: err_cnt=%0d pass=%b, required err_cnt=%0d pass=%b",
               name, err_s, pass_s, e.err, e.pass);
    end
    n_checks++;
    if (step_s !== 3'd7 || busy_s !== 1'b0 || {dr_s, j_s, k_s} !== 3'b000) begin
      n_err++;
      $display("FAIL %s done_outputs: step=%0d busy=%b drives=%b, required 7 0 000",
               name, step_s, busy_s, {dr_s, j_s, k_s});
    end
    n_checks++;
    if (n11 != 3 * passes || cyc_q.size() != 0) begin
      n_err++;
      $display("FAIL %s apply11: j=k=1 cycles=%0d left=%0d, required %0d and 0",
               name, n11, cyc_q.size(), 3 * passes);
    end
    cyc_q.delete();
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_s !== 1'b1 || pass_s !== e.pass || err_s !== 8'(e.err) || busy_s !== 1'b0) begin
      n_err++;
      $display("FAIL %s hold: done=%b pass=%b err=%0d busy=%b, required 1 %b %0d 0",
               name, done_s, pass_s, err_s, busy_s, e.pass, e.err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({j_a, k_a, dr_a, busy_a, done_a, pass_a} !== 6'd0 || err_a !== 8'd0 || step_a !== 3'd0 ||
        {j_b, k_b, dr_b, busy_b, done_b, pass_b} !== 6'd0 || err_b !== 2'd0 || step_b !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: a=%b/%0d/%0d b=%b/%0d/%0d, required all zero",
               {j_a, k_a, dr_a, busy_a, done_a, pass_a}, err_a, step_a,
               {j_b, k_b, dr_b, busy_b, done_b, pass_b}, err_b, step_b);
    end
    rst = 1'b1;
  endtask

  task automatic test_correct;
    run_scored(1'b0, 2'd0, 1, 8, 1'b0, "correct");
  endtask

  // Toggle-as-hold: mismatch count comes from the reference walk.
  task automatic test_toggle_hold;
    run_scored(1'b0, 2'd1, 1, 8, 1'b0, "toggle_hold");
  endtask

  task automatic test_qbar_tied;
    run_scored(1'b0, 2'd2, 1, 8, 1'b0, "qbar_tied");
  endtask

  // Restart straight from DONE with a nonzero count: must clear and pass.
  task automatic test_back_to_back;
    run_scored(1'b0, 2'd0, 1, 8, 1'b0, "back_to_back");
  endtask

  task automatic test_passes2_ignore_start;
    run_scored(1'b1, 2'd0, 2, 2, 1'b1, "passes2");
  endtask

  task automatic test_saturate;
    run_scored(1'b1, 2'd3, 2, 2, 1'b1, "saturate");
  endtask

  task automatic test_reset_midrun;
    int t;
    sel = 1'b0; mode_a = 2'd0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    t = 0;
    while (step_a !== 3'd3 && t < 60) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 60) begin
      n_err++;
      $display("FAIL midrun_reach_step3: step=%0d after %0d cycles, required 3", step_a, t);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({j_a, k_a, dr_a, busy_a, done_a, pass_a} !== 6'd0 || err_a !== 8'd0 || step_a !== 3'd0) begin
      n_err++;
      $display("FAIL midrun_abort: outs=%b err=%0d step=%0d, required zero",
               {j_a, k_a, dr_a, busy_a, done_a, pass_a}, err_a, step_a);
    end
    rst = 1'b1;
    run_scored(1'b0, 2'd0, 1, 8, 1'b0, "after_abort");
  endtask

  task automatic test_reset_vs_start;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b1;
    @(negedge clk);
    rst = 1'b1; start_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || dr_a !== 1'b0 || pass_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dominates: busy=%b done=%b dut_rst=%b pass=%b, required 0 0 0 0",
               busy_a, done_a, dr_a, pass_a);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy_a, done_a);
    end
  endtask

  initial begin
    test_reset;
    test_correct;
    test_toggle_hold;
    test_qbar_tied;
    test_back_to_back;
    test_passes2_ignore_start;
    test_saturate;
    test_reset_midrun;
    test_reset_vs_start;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
